golden_nonce_collector: RTL and testbench

GOLDEN_NONCE_COLLECTOR -- requirements
Module: golden_nonce_collector

---
 rtl/miner_pkg.sv | 28 ++
 rtl/golden_nonce_fifo.sv | 66 ++++++
 rtl/golden_nonce_collector.sv | 213 +++++++++++++++++++++
 tb/tb_golden_nonce_collector.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// miner_pkg: shared state type, nonce width and range helpers for the
// golden-nonce collector.
package miner_pkg;

  localparam int unsigned NONCE_W = 32;

  typedef enum logic [1:0] {StIdle, StSweep, StDrain} sweep_state_e;

  // The step starting at base is the last one once its highest core nonce
  // reaches nonce_max. Done in 33 bits so a step straddling 2^32 still ends.
  function automatic logic step_is_last(input logic [NONCE_W-1:0] base,
                                        input logic [NONCE_W-1:0] nonce_max,
                                        input int unsigned        num_cores);
    logic [NONCE_W:0] top_nonce;
    top_nonce = {1'b0, base} + (NONCE_W+1)'(num_cores - 1);
    return top_nonce >= {1'b0, nonce_max};
  endfunction

  // A core's result counts only if its unwrapped nonce is within the sweep.
  function automatic logic core_in_range(input logic [NONCE_W-1:0] base,
                                         input int unsigned        idx,
                                         input logic [NONCE_W-1:0] nonce_max);
    logic [NONCE_W:0] nonce;
    nonce = {1'b0, base} + (NONCE_W+1)'(idx);
    return nonce <= {1'b0, nonce_max};
  endfunction

endpackage

// File: rtl/golden_nonce_fifo.sv
// golden_nonce_fifo: synchronous FIFO for collected golden nonces.
// Ports: clk_i/rst_i (async active-high), push_i/data_i write side,
// pop_i read side, data_o head entry, valid_o non-empty, full_o full.
// A push while full is accepted only together with a pop (pop-then-push).
module golden_nonce_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == (PtrW+1)'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && valid_o;
    do_push  = push_i && (!full_o || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/golden_nonce_collector.sv
// golden_nonce_collector: sweeps a nonce range across NUM_CORES hashing cores
// and collects their golden tickets into a result FIFO.
// Ports: hash_clk clock, reset async active-high; start/nonce_min/nonce_max
// begin a sweep; core_nonce per-core nonce under test; core_ticket/core_golden
// per-core results; out_valid/out_ready/out_nonce/out_core result stream;
// busy, done (sticky until next start), overflow (sticky lost ticket).
// Build option: GOLDEN_NONCE_DEDUP_EN drops a ticket equal to the most
// recently pushed nonce.
module golden_nonce_collector
  import miner_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LOOP_LOG2  = 0,
  localparam int unsigned CoreW     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                         hash_clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NONCE_W-1:0]           nonce_min,
  input  logic [NONCE_W-1:0]           nonce_max,
  output logic [NUM_CORES*NONCE_W-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]         core_ticket,
  input  logic [NUM_CORES*NONCE_W-1:0] core_golden,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NONCE_W-1:0]           out_nonce,
  output logic [CoreW-1:0]             out_core,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow
);

  localparam int unsigned StepLen = 1 << LOOP_LOG2;
  localparam int unsigned CntW    = LOOP_LOG2 + 2;
  localparam logic [CntW-1:0] StepLast  = CntW'(StepLen - 1);
  localparam logic [CntW-1:0] DrainLast = CntW'(StepLen + 1);

  sweep_state_e                 state_q, state_d;
  logic [NONCE_W-1:0]           base_q, base_d, max_q, max_d;
  logic [NUM_CORES*NONCE_W-1:0] core_nonce_q, core_nonce_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic                         done_q, done_d;

  logic [NUM_CORES-1:0] pend_vld_q, pend_vld_d;
  logic [NONCE_W-1:0]   pend_nonce_q [NUM_CORES];
  logic [NONCE_W-1:0]   pend_nonce_d [NUM_CORES];
  logic [CoreW-1:0]     last_grant_q, last_grant_d;
  logic                 overflow_q, overflow_d;

  logic                 grant_found, push, fifo_full;
  logic [CoreW-1:0]     grant_idx, cand_idx;
  logic [NONCE_W-1:0]   push_nonce;
  logic [NUM_CORES-1:0] dup;

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign core_nonce = core_nonce_q;

  // Sweep sequencing: each step lasts StepLen cycles, drain covers ticket latency.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    max_d        = max_q;
    core_nonce_d = core_nonce_q;
    cnt_d        = cnt_q;
    done_d       = done_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSweep;
          base_d  = nonce_min;
          max_d   = nonce_max;
          cnt_d   = '0;
          done_d  = 1'b0;
          for (int unsigned i = 0; i < NUM_CORES; i++) begin
            core_nonce_d[i*NONCE_W +: NONCE_W] = nonce_min + NONCE_W'(i);
          end
        end
      end
      StSweep: begin
        if (cnt_q == StepLast) begin
          cnt_d = '0;
          if (step_is_last(base_q, max_q, NUM_CORES)) begin
            state_d = StDrain;
          end else begin
            base_d = base_q + NONCE_W'(NUM_CORES);
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
              core_nonce_d[i*NONCE_W +: NONCE_W] =
                  core_nonce_q[i*NONCE_W +: NONCE_W] + NONCE_W'(NUM_CORES);
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending registers: one round-robin grant into the FIFO per cycle, then
  // new tickets land (so a ticket on a core granted this cycle is not a loss).
  always_comb begin
    pend_vld_d   = pend_vld_q;
    pend_nonce_d = pend_nonce_q;
    last_grant_d = last_grant_q;
    overflow_d   = overflow_q;
    grant_found  = 1'b0;
    grant_idx    = '0;
    cand_idx     = '0;
    for (int unsigned n = 1; n <= NUM_CORES; n++) begin
      cand_idx = CoreW'((32'(last_grant_q) + n) % NUM_CORES);
      if (!grant_found && pend_vld_q[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    push       = grant_found && (!fifo_full || (out_valid && out_ready));
    push_nonce = pend_nonce_q[grant_idx];
    if (push) begin
      pend_vld_d[grant_idx] = 1'b0;
      last_grant_d          = grant_idx;
    end
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (core_ticket[i] && busy && !dup[i] && core_in_range(base_q, i, max_q)) begin
        if (pend_vld_d[i]) begin
          overflow_d = 1'b1;
        end
        pend_vld_d[i]   = 1'b1;
        pend_nonce_d[i] = core_golden[i*NONCE_W +: NONCE_W];
      end
    end
  end

`ifdef GOLDEN_NONCE_DEDUP_EN
  logic [NONCE_W-1:0] last_push_q, last_push_d;
  logic               last_push_vld_q, last_push_vld_d;

  always_comb begin
    last_push_d     = last_push_q;
    last_push_vld_d = last_push_vld_q;
    if (push) begin
      last_push_d     = push_nonce;
      last_push_vld_d = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      dup[i] = last_push_vld_q && (core_golden[i*NONCE_W +: NONCE_W] == last_push_q);
    end
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      last_push_q     <= '0;
      last_push_vld_q <= 1'b0;
    end else begin
      last_push_q     <= last_push_d;
      last_push_vld_q <= last_push_vld_d;
    end
  end
`else
  assign dup = '0;
`endif

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      base_q       <= '0;
      max_q        <= '0;
      core_nonce_q <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      pend_vld_q   <= '0;
      pend_nonce_q <= '{default: '0};
      last_grant_q <= CoreW'(NUM_CORES - 1);
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      max_q        <= max_d;
      core_nonce_q <= core_nonce_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      pend_vld_q   <= pend_vld_d;
      pend_nonce_q <= pend_nonce_d;
      last_grant_q <= last_grant_d;
      overflow_q   <= overflow_d;
    end
  end

  golden_nonce_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W + CoreW)
  ) u_fifo (
    .clk_i   (hash_clk),
    .rst_i   (reset),
    .push_i  (push),
    .data_i  ({grant_idx, push_nonce}),
    .pop_i   (out_ready),
    .data_o  ({out_core, out_nonce}),
    .valid_o (out_valid),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_golden_nonce_collector.sv
module tb_golden_nonce_collector;

  logic         hash_clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  nonce_min, nonce_max;
  logic [127:0] core_nonce, core_nonce2;
  logic [3:0]   core_ticket;
  logic [127:0] core_golden;
  logic         out_ready;
  logic         out_valid, out_valid2;
  logic [31:0]  out_nonce, out_nonce2;
  logic [1:0]   out_core, out_core2;
  logic         busy, done, overflow;
  logic         busy2, done2, overflow2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  always #5 hash_clk = ~hash_clk;

  golden_nonce_collector #(
    .NUM_CORES  (4),
    .FIFO_DEPTH (8),
    .LOOP_LOG2  (0)
  ) dut (
    .hash_clk    (hash_clk),
    .reset       (reset),
    .start       (start),
    .nonce_min   (nonce_min),
    .nonce_max   (nonce_max),
    .core_nonce  (core_nonce),
    .core_ticket (core_ticket),
    .core_golden (core_golden),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_nonce   (out_nonce),
    .out_core    (out_core),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  // Shallow-FIFO instance sharing all inputs, used for backpressure cases.
  golden_nonce_collector #(
    .NUM_CORES  (4),
    .FIFO_DEPTH (2),
    .LOOP_LOG2  (0)
  ) dut2 (
    .hash_clk    (hash_clk),
    .reset       (reset),
    .start       (start),
    .nonce_min   (nonce_min),
    .nonce_max   (nonce_max),
    .core_nonce  (core_nonce2),
    .core_ticket (core_ticket),
    .core_golden (core_golden),
    .out_valid   (out_valid2),
    .out_ready   (out_ready),
    .out_nonce   (out_nonce2),
    .out_core    (out_core2),
    .busy        (busy2),
    .done        (done2),
    .overflow    (overflow2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hash_clk);
    @(negedge hash_clk);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    start       = 1'b0;
    core_ticket = '0;
    core_golden = '0;
    out_ready   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] lo, input logic [31:0] hi);
    nonce_min = lo;
    nonce_max = hi;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 50) begin
      tick();
      k++;
    end
    check(tag, done, 1);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    nonce_min   = '0;
    nonce_max   = '0;
    core_ticket = '0;
    core_golden = '0;
    out_ready   = 1'b0;
    @(negedge hash_clk);

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_nonce", out_nonce, 0);
    check("rst_out_core", out_core, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_core_nonce_lo", core_nonce[63:0], 0);
    check("rst_core_nonce_hi", core_nonce[127:64], 0);

    // Single ticket on core 2 at step 0
    do_reset();
    do_start(32'h1DAC2B7A, 32'h1DAC2B81);
    check("s0_core2_nonce", core_nonce[95:64], 32'h1DAC2B7C);
    check("s0_core0_nonce", core_nonce[31:0], 32'h1DAC2B7A);
    check("s0_busy", busy, 1);
    core_ticket[2]        = 1'b1;
    core_golden[95:64]    = 32'h1DAC2B7C;
    tick();
    core_ticket = '0;
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_nonce", out_nonce, 32'h1DAC2B7C);
    check("t1_core", out_core, 2);
    out_ready = 1'b1;
    tick();
    check("t1_popped", out_valid, 0);
    wait_done("t1_done");
    check("t1_idle", busy, 0);

    // Three same-cycle tickets; start while busy is ignored
    do_reset();
    out_ready = 1'b1;
    do_start(32'h00000100, 32'h0000FFFF);
    check("ign_first", core_nonce[31:0], 32'h100);
    tick();
    tick();
    tick();
    check("ign_step3", core_nonce[31:0], 32'h10C);
    do_start(32'h00005000, 32'h0000FFFF);
    check("ign_start", core_nonce[31:0], 32'h110);
    check("ign_done", done, 0);
    core_ticket = 4'b1011;
    core_golden = {32'hA3, 32'h0, 32'hA1, 32'hA0};
    tick();
    core_ticket = '0;
    tick();
    check("rr_core_a", {out_valid, out_core}, {1'b1, 2'd0});
    check("rr_nonce_a", out_nonce, 32'hA0);
    tick();
    check("rr_core_b", {out_valid, out_core}, {1'b1, 2'd1});
    tick();
    check("rr_core_c", {out_valid, out_core}, {1'b1, 2'd3});
    check("rr_nonce_c", out_nonce, 32'hA3);
    tick();
    check("rr_empty", out_valid, 0);

    // Backpressure on the depth-2 instance
    do_reset();
    do_start(32'h00000100, 32'h0000FFFF);
    for (int c = 0; c < 4; c++) begin
      core_ticket[c]          = 1'b1;
      core_golden[c*32 +: 32] = 32'hB0 + 32'(c);
      tick();
      core_ticket = '0;
      tick();
    end
    check("bp_valid", out_valid2, 1);
    check("bp_head", out_nonce2, 32'hB0);
    check("bp_no_ovf", overflow2, 0);
    core_ticket[2]     = 1'b1;
    core_golden[95:64] = 32'hC2;
    tick();
    core_ticket = '0;
    check("bp_ovf", overflow2, 1);
    check("bp_deep_no_ovf", overflow, 0);
    out_ready = 1'b1;
    tick();
    check("bp_pop1", {out_valid2, out_nonce2}, {1'b1, 32'hB1});
    tick();
    check("bp_pop2", {out_valid2, out_core2, out_nonce2}, {1'b1, 2'd2, 32'hC2});
    tick();
    check("bp_pop3", {out_valid2, out_core2, out_nonce2}, {1'b1, 2'd3, 32'hB3});

    // Sweep at the top of the nonce space
    do_reset();
    do_start(32'hFFFFFFFE, 32'hFFFFFFFF);
    check("top_core0", core_nonce[31:0], 32'hFFFFFFFE);
    check("top_core2", core_nonce[95:64], 32'h0);
    core_ticket = 4'b0110;
    core_golden = {32'h0, 32'h0, 32'hFFFFFFFF, 32'h0};
    tick();
    core_ticket = '0;
    tick();
    check("top_out", {out_valid, out_core, out_nonce}, {1'b1, 2'd1, 32'hFFFFFFFF});
    out_ready = 1'b1;
    tick();
    check("top_discard", out_valid, 0);
    wait_done("top_done");
    check("top_idle", busy, 0);
    check("top_no_wrap", core_nonce[31:0], 32'hFFFFFFFE);

    // Repeated identical ticket
    do_reset();
    out_ready = 1'b1;
    do_start(32'h1DAC2B00, 32'hFFFFFF00);
    n_out = 0;
    for (int r = 0; r < 2; r++) begin
      core_ticket[2]     = 1'b1;
      core_golden[95:64] = 32'h1DAC2B7C;
      tick();
      core_ticket = '0;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (out_valid) n_out++;
      end
    end
`ifdef GOLDEN_NONCE_DEDUP_EN
    check("dedup_count", n_out, 1);
`else
    check("dedup_count", n_out, 2);
`endif

    // Asynchronous reset mid-sweep with three entries queued
    do_reset();
    do_start(32'h00000100, 32'h0000FFFF);
    core_ticket = 4'b0111;
    core_golden = {32'h0, 32'hD2, 32'hD1, 32'hD0};
    tick();
    core_ticket = '0;
    tick();
    tick();
    tick();
    check("ar_pre_valid", out_valid, 1);
    check("ar_pre_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_busy", busy, 0);
    check("ar_nonce", out_nonce, 0);
    check("ar_valid2", out_valid2, 0);
    tick();
    reset = 1'b0;
    tick();
    check("ar_stays_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
